// File: rtl/frost32_mem_arbiter.sv
// rtl/frost32_mem_arbiter.sv - two-requester (fetch/data) round-robin arbiter for a single memory port
// Checks alignment, issues a one-cycle memory strobe, waits out stalls with a timeout, then pulses done.
module frost32_mem_arbiter #(
    parameter int WIDTH__DATA    = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   in_req_0,
    input  logic [WIDTH__DATA-1:0] in_addr_0,
    input  logic [WIDTH__DATA-1:0] in_wdata_0,
    input  logic                   in_access_type_0,
    input  logic [1:0]             in_access_size_0,
    output logic                   out_done_0,
    output logic                   out_err_0,

    input  logic                   in_req_1,
    input  logic [WIDTH__DATA-1:0] in_addr_1,
    input  logic [WIDTH__DATA-1:0] in_wdata_1,
    input  logic                   in_access_type_1,
    input  logic [1:0]             in_access_size_1,
    output logic                   out_done_1,
    output logic                   out_err_1,

    output logic [WIDTH__DATA-1:0] out_rdata,

    output logic                   out_req_mem_access,
    output logic [WIDTH__DATA-1:0] out_addr,
    output logic [WIDTH__DATA-1:0] out_data,
    output logic                   out_access_type,
    output logic [1:0]             out_access_size,
    input  logic [WIDTH__DATA-1:0] in_mem_data,
    input  logic                   in_mem_stall
);

    localparam int CW = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] SIZE_32  = 2'd0;
    localparam logic [1:0] SIZE_16  = 2'd1;
    localparam logic [1:0] SIZE_BAD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    logic                   r_last_grant;
    logic                   r_idx;
    logic [CW-1:0]          r_cnt;
    logic                   r_req_mem;
    logic                   r_done_0;
    logic                   r_done_1;
    logic                   r_err_0;
    logic                   r_err_1;
    logic [WIDTH__DATA-1:0] r_rdata;
    logic [WIDTH__DATA-1:0] r_addr;
    logic [WIDTH__DATA-1:0] r_data;
    logic                   r_type;
    logic [1:0]             r_size;

    logic                   w_any_req;
    logic                   w_grant;
    logic [WIDTH__DATA-1:0] w_addr;
    logic [WIDTH__DATA-1:0] w_wdata;
    logic                   w_type;
    logic [1:0]             w_size;
    logic                   w_bad;

    // On a tie the requester not served last wins; otherwise whoever is asking.
    assign w_any_req = in_req_0 | in_req_1;
    assign w_grant   = (in_req_0 & in_req_1) ? ~r_last_grant : in_req_1;
    assign w_addr    = w_grant ? in_addr_1        : in_addr_0;
    assign w_wdata   = w_grant ? in_wdata_1       : in_wdata_0;
    assign w_type    = w_grant ? in_access_type_1 : in_access_type_0;
    assign w_size    = w_grant ? in_access_size_1 : in_access_size_0;
    assign w_bad     = (w_size == SIZE_BAD)
                     | ((w_size == SIZE_32) && (w_addr[1:0] != 2'b00))
                     | ((w_size == SIZE_16) && w_addr[0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_idx        <= 1'b0;
            r_cnt        <= '0;
            r_req_mem    <= 1'b0;
            r_done_0     <= 1'b0;
            r_done_1     <= 1'b0;
            r_err_0      <= 1'b0;
            r_err_1      <= 1'b0;
            r_rdata      <= '0;
            r_addr       <= '0;
            r_data       <= '0;
            r_type       <= 1'b0;
            r_size       <= 2'd0;
        end else begin
            r_req_mem <= 1'b0;
            r_done_0  <= 1'b0;
            r_done_1  <= 1'b0;
            r_err_0   <= 1'b0;
            r_err_1   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_idx  <= w_grant;
                        r_addr <= w_addr;
                        r_data <= w_wdata;
                        r_type <= w_type;
                        r_size <= w_size;
                        if (w_bad) begin
                            r_state  <= ST_DONE;
                            r_done_0 <= ~w_grant;
                            r_done_1 <= w_grant;
                            r_err_0  <= ~w_grant;
                            r_err_1  <= w_grant;
                        end else begin
                            r_state   <= ST_ISSUE;
                            r_req_mem <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                    r_cnt   <= '0;
                end
                ST_WAIT: begin
                    if (!in_mem_stall) begin
                        if (!r_type) begin
                            r_rdata <= in_mem_data;
                        end
                        r_state  <= ST_DONE;
                        r_done_0 <= ~r_idx;
                        r_done_1 <= r_idx;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state  <= ST_DONE;
                        r_done_0 <= ~r_idx;
                        r_done_1 <= r_idx;
                        r_err_0  <= ~r_idx;
                        r_err_1  <= r_idx;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_last_grant <= r_idx;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_done_0         = r_done_0;
    assign out_done_1         = r_done_1;
    assign out_err_0          = r_err_0;
    assign out_err_1          = r_err_1;
    assign out_rdata          = r_rdata;
    assign out_req_mem_access = r_req_mem;
    assign out_addr           = r_addr;
    assign out_data           = r_data;
    assign out_access_type    = r_type;
    assign out_access_size    = r_size;

endmodule
